// File: rtl/stepper_pkg.sv
// Shared state encoding and helpers for stepper motion blocks.
package stepper_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEL  = 3'd1,
    CRUISE = 3'd2,
    DECEL  = 3'd3,
    DONE   = 3'd4
  } step_state_t;

  function automatic logic is_motion(input step_state_t s);
    return (s == ACCEL) || (s == CRUISE) || (s == DECEL);
  endfunction

endpackage

// File: rtl/step_timer.sv
// Step-interval counter (period = delay+1 cycles while enabled) and PULSE_W-wide step pulse.
// The pulse starts the cycle after the tick and completes even if enable drops.
module step_timer #(
  parameter int CNT_W   = 16,
  parameter int PULSE_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] delay,
  input  logic             enable,
  output logic             tick,
  output logic             pulse
);

  localparam int PW = $clog2(PULSE_W + 1);

  logic [CNT_W-1:0] cnt;
  logic [PW-1:0]    pulse_cnt;

  // >= keeps the timer safe should delay ever drop below the running count
  assign tick  = enable && (cnt >= delay);
  assign pulse = (pulse_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pulse_cnt <= '0;
    end else begin
      if (!enable || tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (tick) begin
        pulse_cnt <= PW'(PULSE_W);
      end else if (pulse_cnt != '0) begin
        pulse_cnt <= pulse_cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/stepper_profile_ctrl.sv
// Trapezoidal/triangular stepper motion profile: ramps the step interval from slow_delay to
// fast_delay, cruises, then ramps back symmetrically; abort forces an early mirrored ramp-down.
module stepper_profile_ctrl
  import stepper_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int STEP_W  = 16,
  parameter int PULSE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dir,
  input  logic              abort,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [CNT_W-1:0]  slow_delay,
  input  logic [CNT_W-1:0]  fast_delay,
  input  logic [CNT_W-1:0]  ramp_dec,
  output logic              motor_step,
  output logic              motor_dir,
  output logic              busy,
  output logic              done
);

  step_state_t       state, state_n;
  logic [STEP_W-1:0] rem, rem_n;
  logic [STEP_W-1:0] accel_cnt, accel_n;
  logic [CNT_W-1:0]  cur_delay, cur_n;
  logic [CNT_W-1:0]  slow_q, fast_q, dec_q;
  logic [CNT_W-1:0]  dn_delay, up_delay;
  logic              load;
  logic              step_tick;

  assign busy = is_motion(state);

  // Saturating ramps: never step past fast_q going down or slow_q going up
  assign dn_delay = (cur_delay > fast_q && (cur_delay - fast_q) > dec_q) ? cur_delay - dec_q : fast_q;
  assign up_delay = (slow_q > cur_delay && (slow_q - cur_delay) > dec_q) ? cur_delay + dec_q : slow_q;

  step_timer #(
    .CNT_W  (CNT_W),
    .PULSE_W(PULSE_W)
  ) u_step_timer (
    .clk   (clk),
    .rst   (rst),
    .delay (cur_delay),
    .enable(busy),
    .tick  (step_tick),
    .pulse (motor_step)
  );

  always_comb begin
    state_n = state;
    rem_n   = rem;
    accel_n = accel_cnt;
    cur_n   = cur_delay;
    load    = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          rem_n   = num_steps;
          accel_n = '0;
          cur_n   = slow_delay;
          if (num_steps == '0) begin
            state_n = DONE;
          end else if (ramp_dec == '0 || fast_delay >= slow_delay) begin
            state_n = CRUISE;
          end else begin
            state_n = ACCEL;
          end
        end
      end

      ACCEL, CRUISE: begin
        if (step_tick) begin
          rem_n = rem - 1'b1;
          if (state == ACCEL) begin
            accel_n = accel_cnt + 1'b1;
          end
        end

        if (abort) begin
          // Ramp-down mirrors the ramp-up, so it needs as many steps as were accelerated
          if (accel_n < rem_n) begin
            rem_n = accel_n;
          end
          state_n = (rem_n == '0) ? DONE : DECEL;
        end else if (step_tick) begin
          if (rem_n == '0) begin
            state_n = DONE;
          end else if (rem_n <= accel_n) begin
            // Hold the current interval so the first decel step repeats the last accel one
            state_n = DECEL;
          end else if (state == ACCEL) begin
            if (cur_delay <= fast_q) begin
              state_n = CRUISE;
            end else begin
              cur_n = dn_delay;
            end
          end
        end
      end

      DECEL: begin
        if (step_tick) begin
          rem_n = rem - 1'b1;
          if (rem_n == '0) begin
            state_n = DONE;
          end else begin
            cur_n = up_delay;
          end
        end
      end

      DONE: begin
        if (!start) begin
          state_n = IDLE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rem       <= '0;
      accel_cnt <= '0;
      cur_delay <= '0;
      slow_q    <= '0;
      fast_q    <= '0;
      dec_q     <= '0;
      motor_dir <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      accel_cnt <= accel_n;
      cur_delay <= cur_n;
      done      <= (state == DONE);
      if (load) begin
        motor_dir <= dir;
        slow_q    <= slow_delay;
        fast_q    <= fast_delay;
        dec_q     <= ramp_dec;
      end
    end
  end

endmodule

// File: doc/stepper_profile_ctrl.md
STEPPER_PROFILE_CTRL -- requirements
Module: stepper_profile_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of step-interval delay and interval counter.
REQ-002 SHALL have parameter STEP_W, default 16, width of step count, remaining-step and accel-step counters.
REQ-003 SHALL have parameter PULSE_W, default 1, motor_step high time in clk cycles (1..min delay).
REQ-004 SHALL have port clk  input  1  system clock (1 MHz nominal); one clock; all logic on posedge clk.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port start  input  1  level request; rising into IDLE begins a move.
REQ-007 SHALL have port dir  input  1  move direction, sampled at start.
REQ-008 SHALL have port abort  input  1  request controlled ramp-down of the active move.
REQ-009 SHALL have port num_steps  input  STEP_W  total steps of the move, sampled at start.
REQ-010 SHALL have port slow_delay  input  CNT_W  initial/final interval, sampled at start.
REQ-011 SHALL have port fast_delay  input  CNT_W  cruise interval, sampled at start.
REQ-012 SHALL have port ramp_dec  input  CNT_W  interval change per step during ramps, sampled at start.
REQ-013 SHALL have port motor_step  output  1  step pulse to driver.
REQ-014 SHALL have port motor_dir  output  1  direction to driver.
REQ-015 SHALL have port busy  output  1  high from first cycle after accepted start until DONE entered.
REQ-016 SHALL have port done  output  1  high in DONE state.

Function
REQ-017 SHALL implement states IDLE, ACCEL, CRUISE, DECEL, DONE.
REQ-018 IDLE: start=1 SHALL latch dir into motor_dir and latch num_steps, slow_delay, fast_delay, ramp_dec; cur_delay<=slow_delay; next ACCEL, or DONE if num_steps=0.
REQ-019 In ACCEL/CRUISE/DECEL, interval counter SHALL increment each cycle; when equal to cur_delay it SHALL clear and emit a step, giving step period cur_delay+1 cycles.
REQ-020 Each step SHALL raise motor_step for exactly PULSE_W cycles and decrement remaining steps.
REQ-021 ACCEL: per step, cur_delay <= max(cur_delay-ramp_dec, fast_delay), saturating without underflow; accel_cnt increments; on reaching fast_delay, next CRUISE.
REQ-022 ACCEL/CRUISE: when remaining steps after the current step <= accel_cnt, next DECEL (triangle profile on short moves).
REQ-023 DECEL: per step, cur_delay <= min(cur_delay+ramp_dec, slow_delay), saturating without overflow.
REQ-024 Last step (remaining reaches 0) in any motion state SHALL transition to DONE in the following cycle; PULSE_W pulse SHALL still complete.
REQ-025 abort=1 in ACCEL or CRUISE SHALL set remaining <= accel_cnt and enter DECEL; abort in DECEL, IDLE or DONE ignored.
REQ-026 ramp_dec=0 or fast_delay>=slow_delay SHALL run the whole move at slow_delay with no ramp (CRUISE directly).
REQ-027 start changes while busy SHALL be ignored; motor_dir SHALL not change during a move.
REQ-028 DONE: motor_step=0; return to IDLE only when start=0.

Reset
REQ-029 rst=1 SHALL, on the next edge, force IDLE, motor_step=0, motor_dir=0, busy=0, done=0, all counters and cur_delay to 0, overriding any other event including mid-pulse and mid-move.

Structure
REQ-030 State encodings SHALL live in shared package stepper_pkg, usable by other stepper blocks.
REQ-031 Step-interval timer and PULSE_W pulse generator SHALL be one sub-module step_timer (inputs delay, enable; output step tick, pulse).

Verification
REQ-032 num_steps=100, slow=10000, fast=4500, ramp_dec=500 -> 12 accel steps, 76 cruise at period 4501, 12 decel, exactly 100 pulses, done high.
REQ-033 num_steps=10, same delays -> triangle: 5 accel, 5 decel, no CRUISE, periods symmetric.
REQ-034 num_steps=0 -> no motor_step pulse, done high 2 cycles after start, busy never high.
REQ-035 abort in CRUISE after 40 steps of num_steps=100 -> exactly 12 further decel steps (52 total), then DONE.
REQ-036 rst asserted mid-pulse with PULSE_W=3 -> motor_step low next edge, state IDLE, new start runs a clean move.
REQ-037 start held high through DONE -> no restart until start low then high; dir toggled mid-move -> motor_dir unchanged.
